lap_recorder: RTL and testbench
===============================

Name: lap_recorder

Overview:
- Captures lap snapshots of the running stopwatch time into a small register-file buffer.
- Lets the user step through the stored laps once the watch is paused.
- Sits downstream of the stopwatch timer and upstream of the bin2bcd/bcd2seg display chain.
- Drives the display with either live time or a recalled lap, and consumes the debounced lap and clear buttons.

Parameters:
- LAP_DEPTH, 8, number of lap entries stored; legal range 1..15.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- run  in  1  stopwatch running flag (run_timer).
- lap  in  1  debounced lap button, active-high level.
- clear  in  1  debounced clear button, active-high level.
- hour  in  6  live hours.
- minute  in  6  live minutes.
- second  in  6  live seconds.
- m_sec  in  7  live centiseconds.
- disp_hour  out  6  displayed hours.
- disp_minute  out  6  displayed minutes.
- disp_second  out  6  displayed seconds.
- disp_m_sec  out  7  displayed centiseconds.
- lap_count  out  4  number of valid stored laps.
- recall_idx  out  4  index of the lap on display, 0 = oldest; 0 in LIVE.
- recall_mode  out  1  1 while a stored lap is displayed.
- full  out  1  lap_count == LAP_DEPTH.
- overflow  out  1  one-cycle pulse when a lap is rejected because the buffer is full.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - state = LIVE;
  - all disp_* = 0, lap_count = 0, recall_idx = 0;
  - recall_mode, full and overflow = 0;
  - edge registers lap_q and clear_q = 0;
  - write pointer = 0.
- Edge detection:
  - lap_rise = lap & ~lap_q; clear_rise = clear & ~clear_q.
  - lap_q and clear_q are registered every cycle.
  - A held button yields exactly one event.
- Outputs are registered: disp_* follow the selected source with 1-cycle latency.
- Entry format is 25 bits: {hour, minute, second, m_sec}. Stored as binary, no BCD conversion here.
- State LIVE:
  - disp_* <= live inputs each cycle.
  - lap_rise with run=1 and lap_count < LAP_DEPTH: write the live inputs sampled that cycle into entry[lap_count]; lap_count += 1.
  - lap_rise with run=1 and full: no write; overflow = 1 for one cycle.
  - lap_rise with run=0 and lap_count > 0: go to RECALL with recall_idx = 0. Next cycle disp_* = entry[0] and recall_mode = 1.
  - lap_rise with run=0 and lap_count = 0: ignored.
- State RECALL:
  - disp_* <= entry[recall_idx] each cycle.
  - lap_rise with recall_idx < lap_count-1: recall_idx += 1.
  - lap_rise with recall_idx = lap_count-1: go to LIVE; recall_idx = 0; recall_mode = 0.
  - run=1 (stopwatch restarted): go to LIVE immediately, same rules as above. A lap_rise in that same cycle is dropped.
- Clear:
  - clear_rise in any state: lap_count = 0, write pointer = 0, recall_idx = 0, state = LIVE, recall_mode = 0, full = 0.
  - Entry storage contents are not erased; they are don't-care once invalid.
  - clear_rise and lap_rise in the same cycle: clear wins and the lap is discarded.
- Stopwatch reset (reset_timer) does not clear laps. Only clear or the reset port does.
- Reset asserted mid-recall returns to LIVE with an empty buffer on the next edge-free cycle after deassertion.
- Counters never wrap: lap_count saturates at LAP_DEPTH, and recall_idx < lap_count always holds.
- Width rules:
  - lap_count and recall_idx are zero-extended to 4 bits.
  - An internal count width of $clog2(LAP_DEPTH+1) is sufficient.

Decomposition:
- Shared package stopwatch_pkg holds:
  - HOUR_W = 6, MIN_W = 6, SEC_W = 6, MSEC_W = 7, LAP_ENTRY_W = 25;
  - the state encoding (LIVE = 1'b0, RECALL = 1'b1);
  - a function to pack/unpack a lap entry.
- One sub-module, lap_mem:
  - LAP_DEPTH x LAP_ENTRY_W register file;
  - synchronous write (we, waddr, wdata), asynchronous read (raddr -> rdata);
  - no reset on storage.
- FSM, edge detection and output registers stay in lap_recorder.

Test Plan:
- Reset asserted asynchronously mid-cycle -> all outputs 0 immediately. After release with run=0 and time 00:00:05.12, disp_* = 0,0,5,12 one cycle later.
- run=1; lap pulses at 00:00:01.25, 00:00:03.50 and 00:01:00.00 -> lap_count = 3, recall_mode = 0, disp_* track live time.
- Then run=0; lap pressed four times -> displays 00:00:01.25, then 00:00:03.50, then 00:01:00.00 with recall_idx 0, 1, 2 and recall_mode = 1. The fourth press returns to LIVE with recall_mode = 0.
- LAP_DEPTH = 8; nine lap pulses while running -> lap_count = 8, full = 1. The ninth press gives a single-cycle overflow pulse and no entry changes.
- In RECALL at recall_idx = 1, clear and lap rise in the same cycle -> lap_count = 0, state LIVE, recall_idx = 0. A subsequent lap with run=0 is ignored.
- Lap held high for 1000 cycles with run=1 -> exactly one capture. run rising to 1 during RECALL -> LIVE on the next cycle, lap_count unchanged.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: time-field widths, lap-recorder state encoding and
// helpers that pack/unpack a 25-bit lap entry {hour, minute, second, m_sec}.
package stopwatch_pkg;

    localparam int HOUR_W      = 6;
    localparam int MIN_W       = 6;
    localparam int SEC_W       = 6;
    localparam int MSEC_W      = 7;
    localparam int LAP_ENTRY_W = HOUR_W + MIN_W + SEC_W + MSEC_W;

    typedef enum logic {
        LIVE   = 1'b0,
        RECALL = 1'b1
    } lap_state_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
        logic [MSEC_W-1:0] m_sec;
    } lap_entry_t;

    function automatic logic [LAP_ENTRY_W-1:0] pack_lap(
        input logic [HOUR_W-1:0] h,
        input logic [MIN_W-1:0]  m,
        input logic [SEC_W-1:0]  s,
        input logic [MSEC_W-1:0] ms
    );
        return {h, m, s, ms};
    endfunction

    function automatic lap_entry_t unpack_lap(input logic [LAP_ENTRY_W-1:0] v);
        return lap_entry_t'(v);
    endfunction

endpackage

// File: rtl/lap_mem.sv
// Lap storage: LAP_DEPTH x LAP_ENTRY_W register file, synchronous write and
// asynchronous read. Storage is never reset; validity is tracked by the owner.
module lap_mem
    import stopwatch_pkg::*;
#(
    parameter int LAP_DEPTH = 8,
    parameter int ADDR_W    = 4
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      waddr_i,
    input  logic [LAP_ENTRY_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]      raddr_i,
    output logic [LAP_ENTRY_W-1:0] rdata_o
);

    logic [LAP_ENTRY_W-1:0] mem_q [LAP_DEPTH];

    // Address decode by comparison keeps the pointer width independent of depth.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LAP_DEPTH; i++) begin
            if (we_i && (waddr_i == ADDR_W'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < LAP_DEPTH; i++) begin
            if (raddr_i == ADDR_W'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/lap_recorder.sv
// Lap recorder: snapshots live stopwatch time on lap presses while running and
// lets the user step through stored laps while paused; drives the display path.
module lap_recorder
    import stopwatch_pkg::*;
#(
    parameter int LAP_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              lap,
    input  logic              clear,
    input  logic [HOUR_W-1:0] hour,
    input  logic [MIN_W-1:0]  minute,
    input  logic [SEC_W-1:0]  second,
    input  logic [MSEC_W-1:0] m_sec,
    output logic [HOUR_W-1:0] disp_hour,
    output logic [MIN_W-1:0]  disp_minute,
    output logic [SEC_W-1:0]  disp_second,
    output logic [MSEC_W-1:0] disp_m_sec,
    output logic [3:0]        lap_count,
    output logic [3:0]        recall_idx,
    output logic              recall_mode,
    output logic              full,
    output logic              overflow
);

    localparam int               CNT_W   = $clog2(LAP_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LAP_DEPTH);

    lap_state_e             state_q, state_d;
    logic                   lap_q, clear_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       idx_inc;
    logic [LAP_ENTRY_W-1:0] disp_q, disp_d;
    logic                   ovf_q, ovf_d;
    logic                   lap_rise, clear_rise;
    logic                   mem_we;
    logic [LAP_ENTRY_W-1:0] live_entry, mem_rdata;
    lap_entry_t             disp_s;

    assign lap_rise   = lap & ~lap_q;
    assign clear_rise = clear & ~clear_q;
    assign live_entry = pack_lap(hour, minute, second, m_sec);
    assign idx_inc    = idx_q + 1'b1;

    // The lap count doubles as the write pointer: entries fill from index 0.
    lap_mem #(
        .LAP_DEPTH(LAP_DEPTH),
        .ADDR_W   (CNT_W)
    ) u_lap_mem (
        .clk_i  (clock),
        .we_i   (mem_we),
        .waddr_i(cnt_q),
        .wdata_i(live_entry),
        .raddr_i(idx_d),
        .rdata_o(mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ovf_d   = 1'b0;
        mem_we  = 1'b0;

        if (clear_rise) begin
            state_d = LIVE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                LIVE: begin
                    if (lap_rise) begin
                        if (run) begin
                            if (cnt_q < DEPTH_C) begin
                                mem_we = 1'b1;
                                cnt_d  = cnt_q + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else if (cnt_q != '0) begin
                            state_d = RECALL;
                            idx_d   = '0;
                        end
                    end
                end
                RECALL: begin
                    // Restarting the watch takes priority over stepping.
                    if (run) begin
                        state_d = LIVE;
                        idx_d   = '0;
                    end else if (lap_rise) begin
                        if (idx_inc < cnt_q) begin
                            idx_d = idx_inc;
                        end else begin
                            state_d = LIVE;
                            idx_d   = '0;
                        end
                    end
                end
            endcase
        end

        // Source chosen from the next state so display and recall_mode change together.
        disp_d = (state_d == RECALL) ? mem_rdata : live_entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LIVE;
            lap_q   <= 1'b0;
            clear_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lap_q   <= lap;
            clear_q <= clear;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign disp_s      = unpack_lap(disp_q);
    assign disp_hour   = disp_s.hour;
    assign disp_minute = disp_s.minute;
    assign disp_second = disp_s.second;
    assign disp_m_sec  = disp_s.m_sec;
    assign lap_count   = 4'(cnt_q);
    assign recall_idx  = 4'(idx_q);
    assign recall_mode = (state_q == RECALL);
    assign full        = (cnt_q == DEPTH_C);
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_lap_recorder.sv
// Directed self-checking bench for lap_recorder (LAP_DEPTH = 8).
module tb_lap_recorder;

    logic       clock = 1'b0;
    logic       reset, run, lap, clear;
    logic [5:0] hour, minute, second;
    logic [6:0] m_sec;
    logic [5:0] disp_hour, disp_minute, disp_second;
    logic [6:0] disp_m_sec;
    logic [3:0] lap_count, recall_idx;
    logic       recall_mode, full, overflow;
    logic [31:0] disp;

    int checks = 0;
    int errors = 0;

    lap_recorder #(.LAP_DEPTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .lap        (lap),
        .clear      (clear),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .m_sec      (m_sec),
        .disp_hour  (disp_hour),
        .disp_minute(disp_minute),
        .disp_second(disp_second),
        .disp_m_sec (disp_m_sec),
        .lap_count  (lap_count),
        .recall_idx (recall_idx),
        .recall_mode(recall_mode),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    assign disp = {7'd0, disp_hour, disp_minute, disp_second, disp_m_sec};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tm(input int h, input int m, input int s, input int ms);
        return {7'd0, 6'(h), 6'(m), 6'(s), 7'(ms)};
    endfunction

    task automatic set_time(input int h, input int m, input int s, input int ms);
        hour   = 6'(h);
        minute = 6'(m);
        second = 6'(s);
        m_sec  = 7'(ms);
    endtask

    task automatic chk_ctl(input string tag, input int cnt, input int idx, input logic mode);
        chk({tag, "_cnt"}, 32'(lap_count), 32'(cnt));
        chk({tag, "_idx"}, 32'(recall_idx), 32'(idx));
        chk({tag, "_mode"}, 32'(recall_mode), 32'(mode));
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; lap = 1'b0; clear = 1'b0;
        set_time(0, 0, 0, 0);
        tick(); tick();
        chk("rst_disp", disp, 32'd0);
        chk_ctl("rst", 0, 0, 1'b0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        // live tracking, then asynchronous reset between clock edges
        set_time(1, 2, 3, 4);
        tick();
        chk("live_pre", disp, tm(1, 2, 3, 4));
        #3 reset = 1'b1;
        #1;
        chk("async_rst_disp", disp, 32'd0);
        chk_ctl("async_rst", 0, 0, 1'b0);
        set_time(0, 0, 5, 12);
        reset = 1'b0;
        tick();
        chk("post_rst_disp", disp, tm(0, 0, 5, 12));

        // three laps while running
        run = 1'b1;
        set_time(0, 0, 1, 25); lap = 1'b1; tick();
        chk("lap1_disp", disp, tm(0, 0, 1, 25));
        chk_ctl("lap1", 1, 0, 1'b0);
        lap = 1'b0; tick();
        set_time(0, 0, 3, 50); lap = 1'b1; tick();
        lap = 1'b0; tick();
        set_time(0, 1, 0, 0); lap = 1'b1; tick();
        lap = 1'b0; set_time(0, 1, 0, 37); tick();
        chk_ctl("lap3", 3, 0, 1'b0);
        chk("lap3_track", disp, tm(0, 1, 0, 37));

        // pause and step through the three laps
        run = 1'b0; set_time(0, 5, 5, 5);
        lap = 1'b1; tick();
        chk("rc0_disp", disp, tm(0, 0, 1, 25));
        chk_ctl("rc0", 3, 0, 1'b1);
        lap = 1'b0; tick();
        lap = 1'b1; tick();
        chk("rc1_disp", disp, tm(0, 0, 3, 50));
        chk_ctl("rc1", 3, 1, 1'b1);
        lap = 1'b0; tick();
        lap = 1'b1; tick();
        chk("rc2_disp", disp, tm(0, 1, 0, 0));
        chk_ctl("rc2", 3, 2, 1'b1);
        lap = 1'b0; tick();
        lap = 1'b1; tick();
        chk("rc_exit_disp", disp, tm(0, 5, 5, 5));
        chk_ctl("rc_exit", 3, 0, 1'b0);
        lap = 1'b0; tick();

        // fill the buffer, then one rejected lap
        run = 1'b1;
        for (int k = 3; k < 8; k++) begin
            set_time(k, k, k, k);
            lap = 1'b1; tick();
            lap = 1'b0; tick();
        end
        chk("fill_cnt", 32'(lap_count), 32'd8);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf", 32'(overflow), 32'd0);
        set_time(9, 9, 9, 9); lap = 1'b1; tick();
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(lap_count), 32'd8);
        lap = 1'b0; tick();
        chk("ovf_end", 32'(overflow), 32'd0);
        chk("ovf_full", 32'(full), 32'd1);

        // walk all eight entries; entry 7 must not hold the rejected time
        run = 1'b0;
        for (int p = 0; p < 8; p++) begin
            lap = 1'b1; tick();
            if (p == 0) chk("walk0", disp, tm(0, 0, 1, 25));
            if (p == 3) chk("walk3", disp, tm(3, 3, 3, 3));
            if (p == 7) begin
                chk("walk7", disp, tm(7, 7, 7, 7));
                chk_ctl("walk7", 8, 7, 1'b1);
            end
            lap = 1'b0; tick();
        end
        lap = 1'b1; tick();
        chk_ctl("walk_exit", 8, 0, 1'b0);
        lap = 1'b0; tick();

        // clear and lap together while recalling index 1
        lap = 1'b1; tick();
        lap = 1'b0; tick();
        lap = 1'b1; tick();
        chk_ctl("pre_clr", 8, 1, 1'b1);
        lap = 1'b0; tick();
        clear = 1'b1; lap = 1'b1; tick();
        chk_ctl("clr", 0, 0, 1'b0);
        chk("clr_full", 32'(full), 32'd0);
        clear = 1'b0; lap = 1'b0; tick();
        lap = 1'b1; tick();
        chk_ctl("empty_lap", 0, 0, 1'b0);
        lap = 1'b0; tick();

        // held lap captures once
        run = 1'b1; set_time(0, 0, 2, 20); lap = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (c == 500) set_time(0, 0, 8, 80);
        end
        chk("hold_cnt", 32'(lap_count), 32'd1);
        lap = 1'b0; tick();

        // restarting the watch during recall returns to live, drops the lap
        run = 1'b0; set_time(0, 4, 4, 4);
        lap = 1'b1; tick();
        chk("rc_hold_disp", disp, tm(0, 0, 2, 20));
        chk_ctl("rc_hold", 1, 0, 1'b1);
        lap = 1'b0; tick();
        run = 1'b1; lap = 1'b1; set_time(0, 3, 3, 3); tick();
        chk_ctl("run_exit", 1, 0, 1'b0);
        chk("run_exit_disp", disp, tm(0, 3, 3, 3));
        lap = 1'b0; tick();
        chk("run_exit_cnt", 32'(lap_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
